// File: rtl/ps2_letter_queue.sv
// PS/2 Set-2 byte stream to letter-code queue: tracks F0/E0 prefixes, filters held-key
// repeats, and buffers decoded letters in a small FIFO with a valid/ready output.
module ps2_letter_queue #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned CODE_W        = 5,
    parameter int unsigned REPEAT_FILTER = 1,
    parameter int unsigned ENABLE_ENTER  = 1,
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W        = PTR_W + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        scan_code,
    input  logic              scan_valid,
    output logic [CODE_W-1:0] letter,
    output logic              letter_valid,
    input  logic              letter_ready,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              overflow,
    output logic              key_held
);

    localparam logic [7:0] BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX   = 8'hE0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BRK,
        S_EXT,
        S_EXT_BRK
    } state_e;

    state_e              state_q, state_d;
    logic                key_held_q, key_held_d;
    logic [7:0]          held_code_q, held_code_d;
    logic                push_q, push_d;
    logic [CODE_W-1:0]   push_code_q, push_code_d;

    logic [CODE_W-1:0]   mem_q [FIFO_DEPTH];
    logic [CODE_W-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CODE_W-1:0]   letter_q, letter_d;
    logic                letter_valid_q, letter_valid_d;
    logic                overflow_q, overflow_d;

    logic                map_hit_c;
    logic [CODE_W-1:0]   map_code_c;
    logic                pop_c;
    logic                full_c;
    logic                do_push_c;

    // Set-2 make code to letter code
    always_comb begin
        map_hit_c  = 1'b1;
        map_code_c = '0;
        case (scan_code)
            8'h1C: map_code_c = CODE_W'(0);
            8'h32: map_code_c = CODE_W'(1);
            8'h21: map_code_c = CODE_W'(2);
            8'h23: map_code_c = CODE_W'(3);
            8'h24: map_code_c = CODE_W'(4);
            8'h2B: map_code_c = CODE_W'(5);
            8'h34: map_code_c = CODE_W'(6);
            8'h33: map_code_c = CODE_W'(7);
            8'h43: map_code_c = CODE_W'(8);
            8'h3B: map_code_c = CODE_W'(9);
            8'h42: map_code_c = CODE_W'(10);
            8'h4B: map_code_c = CODE_W'(11);
            8'h3A: map_code_c = CODE_W'(12);
            8'h31: map_code_c = CODE_W'(13);
            8'h44: map_code_c = CODE_W'(14);
            8'h4D: map_code_c = CODE_W'(15);
            8'h15: map_code_c = CODE_W'(16);
            8'h2D: map_code_c = CODE_W'(17);
            8'h1B: map_code_c = CODE_W'(18);
            8'h2C: map_code_c = CODE_W'(19);
            8'h3C: map_code_c = CODE_W'(20);
            8'h2A: map_code_c = CODE_W'(21);
            8'h1D: map_code_c = CODE_W'(22);
            8'h22: map_code_c = CODE_W'(23);
            8'h35: map_code_c = CODE_W'(24);
            8'h1A: map_code_c = CODE_W'(25);
            8'h5A: begin
                map_hit_c  = (ENABLE_ENTER != 0);
                map_code_c = CODE_W'(26);
            end
            default: map_hit_c = 1'b0;
        endcase
    end

    // Prefix FSM and held-key tracking; a make event is staged in push_q for the FIFO
    always_comb begin
        state_d     = state_q;
        key_held_d  = key_held_q;
        held_code_d = held_code_q;
        push_d      = 1'b0;
        push_code_d = push_code_q;
        if (scan_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (scan_code == BREAK_PREFIX) begin
                        state_d = S_BRK;
                    end else if (scan_code == EXT_PREFIX) begin
                        state_d = S_EXT;
                    end else if (map_hit_c) begin
                        if (!((REPEAT_FILTER != 0) && key_held_q && (scan_code == held_code_q))) begin
                            push_d      = 1'b1;
                            push_code_d = map_code_c;
                            key_held_d  = 1'b1;
                            held_code_d = scan_code;
                        end
                    end
                end
                S_BRK: begin
                    state_d = S_IDLE;
                    if (key_held_q && (scan_code == held_code_q)) begin
                        key_held_d = 1'b0;
                    end
                end
                S_EXT: begin
                    state_d = (scan_code == BREAK_PREFIX) ? S_EXT_BRK : S_IDLE;
                end
                S_EXT_BRK: state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // FIFO: a write into a full queue succeeds only when the head leaves in the same cycle
    always_comb begin
        pop_c     = letter_valid_q && letter_ready;
        full_c    = (count_q == CNT_W'(FIFO_DEPTH));
        do_push_c = push_q && (!full_c || pop_c);
        overflow_d = push_q && full_c && !pop_c;
        mem_d = mem_q;
        if (do_push_c) begin
            mem_d[wr_ptr_q] = push_code_q;
        end
        wr_ptr_d = do_push_c ? PTR_W'(wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop_c     ? PTR_W'(rd_ptr_q + 1'b1) : rd_ptr_q;
        case ({do_push_c, pop_c})
            2'b10:   count_d = CNT_W'(count_q + 1'b1);
            2'b01:   count_d = CNT_W'(count_q - 1'b1);
            default: count_d = count_q;
        endcase
        letter_valid_d = (count_d != '0);
        letter_d       = (count_d != '0) ? mem_d[rd_ptr_d] : letter_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= S_IDLE;
            key_held_q     <= 1'b0;
            held_code_q    <= '0;
            push_q         <= 1'b0;
            push_code_q    <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            letter_q       <= '0;
            letter_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            key_held_q     <= key_held_d;
            held_code_q    <= held_code_d;
            push_q         <= push_d;
            push_code_q    <= push_code_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            letter_q       <= letter_d;
            letter_valid_q <= letter_valid_d;
            overflow_q     <= overflow_d;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign letter       = letter_q;
    assign letter_valid = letter_valid_q;
    assign fifo_count   = count_q;
    assign overflow     = overflow_q;
    assign key_held     = key_held_q;

endmodule

// File: tb/tb_ps2_letter_queue.sv
// Directed bench for ps2_letter_queue: stimulus pushes expected letter codes into a
// scoreboard queue; a monitor pops and compares on every accepted handshake.
module tb_ps2_letter_queue;

    logic       clk;
    logic       resetn;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic [4:0] letter;
    logic       letter_valid;
    logic       letter_ready;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       key_held;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    ps2_letter_queue dut (
        .clk          (clk),
        .resetn       (resetn),
        .scan_code    (scan_code),
        .scan_valid   (scan_valid),
        .letter       (letter),
        .letter_valid (letter_valid),
        .letter_ready (letter_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .key_held     (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk) #1;
    endtask

    // one-cycle strobe; returns 1ns after the edge that samples the byte
    task automatic send(input logic [7:0] b);
        @(posedge clk) #1;
        scan_code  = b;
        scan_valid = 1'b1;
        @(posedge clk) #1;
        scan_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        letter_ready = 1'b1;
        idle(n);
        letter_ready = 1'b0;
        chk("drain_count", int'(fifo_count), 0);
    endtask

    // Scoreboard monitor: a head with valid&ready at this point is consumed at the next edge
    always @(negedge clk) begin
        if (resetn && letter_valid && letter_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_letter: got %0d expected none", letter);
            end else begin
                chk("scoreboard_letter", int'(letter), exp_q.pop_front());
            end
        end
    end

    initial begin
        resetn       = 1'b0;
        scan_code    = 8'h00;
        scan_valid   = 1'b0;
        letter_ready = 1'b0;
        idle(3);
        chk("rst_valid", int'(letter_valid), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_letter", int'(letter), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_key_held", int'(key_held), 0);
        resetn = 1'b1;

        // 1: single make, one-cycle latency into the FIFO
        send(8'h1C); exp_q.push_back(0);
        chk("t1_not_yet_valid", int'(letter_valid), 0);
        idle(1);
        chk("t1_valid", int'(letter_valid), 1);
        chk("t1_letter", int'(letter), 0);
        chk("t1_count", int'(fifo_count), 1);
        chk("t1_key_held", int'(key_held), 1);
        drain(1);

        // 2: repeat filter and release
        send(8'hF0); send(8'h1C);
        idle(1);
        chk("t2_released", int'(key_held), 0);
        send(8'h1C); exp_q.push_back(0);
        send(8'h1C); send(8'h1C);
        idle(2);
        chk("t2_one_entry", int'(fifo_count), 1);
        send(8'hF0); send(8'h1C);
        idle(1);
        chk("t2_released2", int'(key_held), 0);
        send(8'h1C); exp_q.push_back(0);
        idle(2);
        chk("t2_two_entries", int'(fifo_count), 2);
        drain(3);

        // 3: extended make/break dropped, held key untouched
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        idle(2);
        chk("t3_no_push", int'(fifo_count), 0);
        chk("t3_key_held", int'(key_held), 1);
        send(8'h32); exp_q.push_back(1);
        idle(1);
        chk("t3_letter_b", int'(letter), 1);
        drain(2);

        // 4: overflow on fifth distinct letter
        send(8'h1C); exp_q.push_back(0);
        send(8'h32); exp_q.push_back(1);
        send(8'h21); exp_q.push_back(2);
        send(8'h23); exp_q.push_back(3);
        send(8'h24);
        chk("t4_ovf_before", int'(overflow), 0);
        idle(1);
        chk("t4_ovf_pulse", int'(overflow), 1);
        chk("t4_count_full", int'(fifo_count), 4);
        chk("t4_head", int'(letter), 0);
        idle(1);
        chk("t4_ovf_clear", int'(overflow), 0);
        drain(6);

        // 5: push and pop in the same cycle while full
        send(8'h1C); exp_q.push_back(0);
        send(8'h32); exp_q.push_back(1);
        send(8'h21); exp_q.push_back(2);
        send(8'h23); exp_q.push_back(3);
        idle(2);
        chk("t5_full", int'(fifo_count), 4);
        @(posedge clk) #1;
        scan_code  = 8'h5A;
        scan_valid = 1'b1;
        exp_q.push_back(26);
        @(posedge clk) #1;
        scan_valid   = 1'b0;
        letter_ready = 1'b1;
        @(posedge clk) #1;
        letter_ready = 1'b0;
        chk("t5_count_stays", int'(fifo_count), 4);
        chk("t5_no_overflow", int'(overflow), 0);
        chk("t5_next_head", int'(letter), 1);
        drain(6);

        // 6: reset clears a pending break prefix and a non-empty FIFO
        send(8'h1C); exp_q.push_back(0);
        idle(2);
        chk("t6_pre_count", int'(fifo_count), 1);
        send(8'hF0);
        resetn = 1'b0;
        idle(1);
        chk("t6_rst_valid", int'(letter_valid), 0);
        chk("t6_rst_count", int'(fifo_count), 0);
        chk("t6_rst_key_held", int'(key_held), 0);
        chk("t6_rst_letter", int'(letter), 0);
        chk("t6_rst_overflow", int'(overflow), 0);
        exp_q.delete();
        resetn = 1'b1;
        send(8'h24); exp_q.push_back(4);
        idle(2);
        chk("t6_letter_e", int'(letter), 4);
        chk("t6_count", int'(fifo_count), 1);
        drain(2);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
